instr_mem_sync: RTL and testbench



---
 rtl/instr_mem_sync.sv | 126 ++++++++++++
 tb/tb_instr_mem_sync.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_sync.sv
// Synchronous instruction memory for the fetch stage: one-cycle registered fetch
// with stall/flush and fault flagging, a run-time program-load port and an optional NOP sweep after reset.
module instr_mem_sync #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                DEPTH          = 1024,
  parameter logic [DATA_W-1:0] NOP_WORD       = DATA_W'(32'h00000013),
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              fault,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              ready
);

  localparam int                IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
  logic                instr_valid_q, instr_valid_d;
  logic                fault_q, fault_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic [IDX_W-1:0]    mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic [ADDR_W-1:0]   fetch_word, prog_word;
  logic                fetch_bad, prog_bad;
  logic [IDX_W-1:0]    fetch_idx, prog_idx;

  // A word index at or beyond DEPTH means address bits above the index are set.
  assign fetch_word = fetch_addr >> 2;
  assign prog_word  = prog_addr >> 2;
  assign fetch_bad  = (fetch_addr[1:0] != 2'b00) || (fetch_word >= DEPTH_A);
  assign prog_bad   = (prog_addr[1:0] != 2'b00) || (prog_word >= DEPTH_A);
  assign fetch_idx  = fetch_addr[IDX_W+1:2];
  assign prog_idx   = prog_addr[IDX_W+1:2];

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;
    mem_we        = 1'b0;
    mem_waddr     = prog_idx;
    mem_wdata     = prog_data;

    unique case (state_q)
      S_CLEAR: begin
        instr_valid_d = 1'b0;
        mem_we        = 1'b1;
        mem_waddr     = clr_cnt_q;
        mem_wdata     = NOP_WORD;
        clr_cnt_d     = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_IDX) state_d = S_RUN;
      end
      default: begin
        if (flush) begin
          instr_valid_d = 1'b0;
          fault_d       = 1'b0;
          instr_d       = NOP_WORD;
        end else if (!stall) begin
          if (fetch_req) begin
            instr_valid_d = 1'b1;
            instr_pc_d    = fetch_addr;
            fault_d       = fetch_bad;
            // Array read is combinational on the old contents, so a same-cycle write is not seen.
            instr_d       = fetch_bad ? NOP_WORD : mem[fetch_idx];
          end else begin
            instr_valid_d = 1'b0;
            fault_d       = 1'b0;
          end
        end
        mem_we = prog_we && !prog_bad;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
      clr_cnt_q     <= '0;
      instr_q       <= NOP_WORD;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign fault       = fault_q;
  assign ready       = (state_q == S_RUN);

endmodule

// File: tb/tb_instr_mem_sync.sv
// Scoreboard bench for instr_mem_sync (DEPTH=16): a per-edge reference model queues expected
// outputs and an independent monitor compares them against the DUT after every rising edge.
module tb_instr_mem_sync;
  localparam int          DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        fault;
  logic        prog_we = 1'b0;
  logic [31:0] prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic        ready;

  instr_mem_sync #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .NOP_WORD(NOP), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .stall(stall), .flush(flush), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .fault(fault), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        rdy;
    logic        vld;
    logic        flt;
    logic [31:0] ins;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_instr, m_pc;
  logic        m_valid, m_fault, m_ready;
  int          m_left;

  function automatic bit addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
  endfunction

  task automatic step(input string tag, input bit r, input bit req, input logic [31:0] a,
                      input bit st, input bit fl, input bit we,
                      input logic [31:0] pa, input logic [31:0] pd);
    exp_t e;
    @(negedge clk);
    rst = r; fetch_req = req; fetch_addr = a; stall = st; flush = fl;
    prog_we = we; prog_addr = pa; prog_data = pd;
    if (r) begin
      m_instr = NOP; m_pc = '0; m_valid = 1'b0; m_fault = 1'b0;
      m_ready = 1'b0; m_left = DEPTH;
    end else if (!m_ready) begin
      m_valid = 1'b0;
      m_left--;
      if (m_left == 0) begin
        m_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) m_mem[k] = NOP;
      end
    end else begin
      if (fl) begin
        m_valid = 1'b0; m_fault = 1'b0; m_instr = NOP;
      end else if (!st) begin
        if (req) begin
          m_valid = 1'b1; m_pc = a;
          if (addr_bad(a)) begin m_instr = NOP; m_fault = 1'b1; end
          else begin m_instr = m_mem[a >> 2]; m_fault = 1'b0; end
        end else begin
          m_valid = 1'b0; m_fault = 1'b0;
        end
      end
      if (we && !addr_bad(pa)) m_mem[pa >> 2] = pd;
    end
    e.tag = tag; e.rdy = m_ready; e.vld = m_valid; e.flt = m_fault;
    e.ins = m_instr; e.pc = m_pc;
    exp_q.push_back(e);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic fetch(input string tag, input logic [31:0] a);
    step(tag, 1'b0, 1'b1, a, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic prog(input string tag, input logic [31:0] pa, input logic [31:0] pd);
    step(tag, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, pa, pd);
  endtask

  task automatic chk(input string tag, input string fld, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s.%s: got %h want %h (t=%0t)", tag, fld, got, want, $time);
    end
  endtask

  // Monitor: compares the DUT against the model after each edge a stimulus was issued for.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk(e.tag, "ready", {31'b0, ready}, {31'b0, e.rdy});
      chk(e.tag, "valid", {31'b0, instr_valid}, {31'b0, e.vld});
      chk(e.tag, "fault", {31'b0, fault}, {31'b0, e.flt});
      chk(e.tag, "instr", instr, e.ins);
      chk(e.tag, "pc", instr_pc, e.pc);
    end
  end

  initial begin
    logic [31:0] a, pa;
    int          sel;

    // Reset and sweep, with noise on fetch/program ports that must be ignored
    step("rst", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < DEPTH; i++)
      step("sweep", 1'b0, 1'($urandom_range(0, 1)), 32'(i * 4), 1'b0, 1'b0,
           1'($urandom_range(0, 1)), 32'(i * 4), $urandom);
    fetch("fetch0", 32'h0);

    prog("prog4", 32'h4, 32'h0ff10113);
    prog("prog8", 32'h8, 32'h00200313);
    fetch("f4", 32'h4);
    fetch("f8", 32'h8);

    step("collide", 1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 1'b1, 32'h8, 32'h00730333);
    fetch("refetch8", 32'h8);

    fetch("mis6", 32'h6);
    fetch("oor40", 32'h40);
    prog("prog40", 32'h40, 32'hdeadbeef);
    prog("prog42", 32'h42, 32'hcafef00d);
    fetch("f0_intact", 32'h0);
    fetch("f1_intact", 32'h4);

    fetch("f4b", 32'h4);
    for (int i = 0; i < 3; i++)
      step("stall", 1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step("flush_stall", 1'b0, 1'b1, 32'h8, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    fetch("f8b", 32'h8);
    idle("idle");

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 19);
      a   = (sel == 0) ? $urandom : (sel == 1) ? 32'($urandom_range(0, 79))
                                               : 32'($urandom_range(0, DEPTH + 1) * 4);
      pa  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 79))
                                        : 32'($urandom_range(0, DEPTH - 1) * 4);
      step("rand", 1'b0, 1'($urandom_range(0, 3) != 0), a,
           $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 2) == 0, pa, $urandom);
    end

    // Reset during the sweep restarts it from the beginning
    step("rst2", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 7; i++) idle("sweep2");
    step("rst3", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < DEPTH; i++)
      step("sweep3", 1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 1'b1, 32'h4, 32'h11111111);
    fetch("post_sweep", 32'h4);
    idle("tail");

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
